// File: rtl/led_sang_dan_pkg.sv
// -----------------------------------------------------------------------------
// led_sang_dan_pkg
//   Shared types and default constants for the "LEDs light up one by one,
//   then all turn off" pattern generator.
//
//   Contents:
//     led_state_t      - FSM state encoding (S_FILL, S_HOLD, S_BLINK)
//     LED_WIDTH        - default number of LEDs
//     LED_TICK_DIV     - default clock cycles per pattern step
//     LED_HOLD_STEPS   - default number of steps all-ones stays visible
//     LED_BLINK_COUNT  - default number of off/on blink pairs
//     cnt_width()      - width of a counter that must reach a given value
// -----------------------------------------------------------------------------
package led_sang_dan_pkg;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_HOLD  = 2'd1,
      S_BLINK = 2'd2
   } led_state_t;

   localparam int LED_WIDTH       = 8;
   localparam int LED_TICK_DIV    = 1;
   localparam int LED_HOLD_STEPS  = 1;
   localparam int LED_BLINK_COUNT = 2;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/led_step_tick.sv
// -----------------------------------------------------------------------------
// led_step_tick
//   Step prescaler for the LED pattern FSM. A counter runs 0..DIV-1 and
//   wraps; tick is high during the cycle the counter holds DIV-1, so with
//   DIV = 1 tick is high every cycle.
//
//   Parameters:
//     DIV    - clock cycles per tick (>= 1)
//
//   Ports:
//     clk    in   1  system clock, rising edge
//     reset  in   1  synchronous, active-high; clears the counter
//     tick   out  1  one-cycle step strobe
// -----------------------------------------------------------------------------
module led_step_tick
   import led_sang_dan_pkg::*;
#(
   parameter int DIV = LED_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = cnt_width(DIV - 1);

   logic [CW-1:0] r_cnt = '0;
   logic          w_last;

   assign w_last = (r_cnt == CW'(DIV - 1));
   assign tick   = w_last;

   always_ff @(posedge clk) begin
      if (reset || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_sang_dan_tat_het.sv
// -----------------------------------------------------------------------------
// led_sang_dan_tat_het
//   Free-running LED pattern generator. The LED bank fills from the LSB
//   upward (0x01, 0x03, ... all-ones), holds all-ones for HOLD_STEPS steps,
//   clears to zero for one step and repeats forever.
//
//   Optional feature (macro LED_BLINK_EN):
//     After the hold, the bank blinks BLINK_COUNT off/on pairs before the
//     next fill starts. Without the macro there is no blink state or counter.
//
//   Parameters:
//     WIDTH        - number of LEDs (>= 2)
//     TICK_DIV     - clock cycles per pattern step (>= 1)
//     HOLD_STEPS   - steps all-ones stays visible (>= 1)
//     BLINK_COUNT  - off/on blink pairs, LED_BLINK_EN builds only (>= 1)
//
//   Ports:
//     clk    in   1      system clock, rising edge
//     reset  in   1      synchronous, active-high
//     out    out  WIDTH  LED drive, 1 = on, straight from a flop
// -----------------------------------------------------------------------------
module led_sang_dan_tat_het
   import led_sang_dan_pkg::*;
#(
   parameter int WIDTH       = LED_WIDTH,
   parameter int TICK_DIV    = LED_TICK_DIV,
   parameter int HOLD_STEPS  = LED_HOLD_STEPS,
   parameter int BLINK_COUNT = LED_BLINK_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   // Elaboration-time guard against out-of-range parameters.
   if (WIDTH < 2 || TICK_DIV < 1 || HOLD_STEPS < 1 || BLINK_COUNT < 1) begin : g_param_check
      $error("led_sang_dan_tat_het: illegal parameter value");
   end

   localparam int HOLD_W = cnt_width(HOLD_STEPS);

   // ---------------------------------------------------------------------
   // Step prescaler
   // ---------------------------------------------------------------------
   logic w_tick;

   led_step_tick #(
      .DIV (TICK_DIV)
   ) u_step_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   // ---------------------------------------------------------------------
   // State registers (initial values match reset values so an unreset
   // device still produces the defined sequence)
   // ---------------------------------------------------------------------
   led_state_t        r_state    = S_FILL;
   logic [WIDTH-1:0]  r_out      = '0;
   logic [HOLD_W-1:0] r_hold_cnt = '0;

   led_state_t        w_state_nxt;
   logic [WIDTH-1:0]  w_out_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;

`ifdef LED_BLINK_EN
   localparam int BLINK_W = cnt_width(2 * BLINK_COUNT);

   logic [BLINK_W-1:0] r_blink_cnt = '0;
   logic [BLINK_W-1:0] w_blink_nxt;
`endif

   assign out = r_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FILL;
         r_out      <= '0;
         r_hold_cnt <= '0;
`ifdef LED_BLINK_EN
         r_blink_cnt <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_out      <= w_out_nxt;
         r_hold_cnt <= w_hold_nxt;
`ifdef LED_BLINK_EN
         r_blink_cnt <= w_blink_nxt;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_hold_nxt  = r_hold_cnt;
`ifdef LED_BLINK_EN
      w_blink_nxt = r_blink_cnt;
`endif

      case (r_state)
         S_FILL: begin
            if (w_tick) begin
               w_out_nxt = {r_out[WIDTH-2:0], 1'b1};
               // The shifted value is all-ones exactly when the low bits
               // already are, so the hold decision needs no wide compare.
               if (&r_out[WIDTH-2:0]) begin
                  w_state_nxt = S_HOLD;
                  w_hold_nxt  = HOLD_W'(1);
               end
            end
         end

         S_HOLD: begin
            if (w_tick) begin
               if (r_hold_cnt == HOLD_W'(HOLD_STEPS)) begin
                  w_out_nxt  = '0;
                  w_hold_nxt = '0;
`ifdef LED_BLINK_EN
                  w_state_nxt = S_BLINK;
                  w_blink_nxt = BLINK_W'(1);
`else
                  w_state_nxt = S_FILL;
`endif
               end else begin
                  w_hold_nxt = r_hold_cnt + HOLD_W'(1);
               end
            end
         end

`ifdef LED_BLINK_EN
         S_BLINK: begin
            if (w_tick) begin
               if (r_blink_cnt == BLINK_W'(2 * BLINK_COUNT)) begin
                  w_out_nxt   = '0;
                  w_blink_nxt = '0;
                  w_state_nxt = S_FILL;
               end else begin
                  // out is always all-zeros or all-ones here.
                  w_out_nxt   = ~r_out;
                  w_blink_nxt = r_blink_cnt + BLINK_W'(1);
               end
            end
         end
`endif

         // Unused encodings (including S_BLINK when blinking is not built)
         // recover on the next clock, independent of the step tick.
         default: begin
            w_state_nxt = S_FILL;
            w_out_nxt   = '0;
            w_hold_nxt  = '0;
`ifdef LED_BLINK_EN
            w_blink_nxt = '0;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_led_sang_dan_tat_het.sv
// -----------------------------------------------------------------------------
// tb_led_sang_dan_tat_het
//   Directed bench for led_sang_dan_tat_het. Four instances share one clock:
//     u_d0 - defaults, reset held 2 clocks, later reset mid-sequence
//     u_dn - defaults, reset never asserted
//     u_d4 - TICK_DIV = 4
//     u_d3 - HOLD_STEPS = 3
//   Expected values come from a step-indexed reference of the pattern.
//   Honours LED_BLINK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_led_sang_dan_tat_het;

   localparam int W  = 8;
   localparam int BC = 2;
`ifdef LED_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk = 1'b0;
   logic r0  = 1'b1;
   logic r4  = 1'b1;
   logic r3  = 1'b1;
   logic rn  = 1'b0;

   logic [W-1:0] out0, outn, out4, out3;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   led_sang_dan_tat_het u_d0 (.clk(clk), .reset(r0), .out(out0));
   led_sang_dan_tat_het u_dn (.clk(clk), .reset(rn), .out(outn));
   led_sang_dan_tat_het #(.TICK_DIV(4))   u_d4 (.clk(clk), .reset(r4), .out(out4));
   led_sang_dan_tat_het #(.HOLD_STEPS(3)) u_d3 (.clk(clk), .reset(r3), .out(out3));

   // Reference: value shown at pattern step 'step' (step 0 = 00 after reset).
   function automatic logic [W-1:0] ref_val(input int unsigned step, input int unsigned hold);
      int unsigned per;
      int unsigned pos;
      per = W + hold + (BLINK ? 2 * BC : 0);
      pos = step % per;
      if (pos <= W)
         return W'((1 << pos) - 1);
      else if (pos < W + hold)
         return '1;
      else
         return ((pos - W - hold) % 2 == 1) ? '1 : '0;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned k;
      int unsigned per0;
      per0 = W + 1 + (BLINK ? 2 * BC : 0);

      // Power-up value with no reset and no clock edge yet.
      #1;
      check("noreset_powerup", outn, 8'h00);

      // Reset held for two clocks.
      tick_clk();
      tick_clk();
      check("reset_d0", out0, 8'h00);
      check("reset_d4", out4, 8'h00);
      check("reset_d3", out3, 8'h00);
      check("noreset_step2", outn, ref_val(2, 1));
      r0 = 1'b0;
      r4 = 1'b0;
      r3 = 1'b0;

      // 40 clocks after release: covers 3+ default periods, HOLD_STEPS=3
      // periods and the FF->00 transition of TICK_DIV=4 at clock 36.
      for (k = 1; k <= 40; k++) begin
         tick_clk();
         check($sformatf("d0_clk%0d", k), out0, ref_val(k, 1));
         check($sformatf("dn_clk%0d", k), outn, ref_val(k + 2, 1));
         check($sformatf("d3_clk%0d", k), out3, ref_val(k, 3));
         check($sformatf("d4_clk%0d", k), out4, ref_val(k / 4, 1));
      end
      k = 40;

      // Run u_d0 forward to the 0x1F step, then reset it mid-sequence.
      for (int g = 0; g < 20 && (k % per0) != 5; g++) begin
         tick_clk();
         k++;
      end
      check("d0_at_1F", out0, 8'h1F);
      r0 = 1'b1;
      tick_clk();
      check("d0_midreset", out0, 8'h00);
      r0 = 1'b0;
      tick_clk();
      check("d0_after_midreset", out0, 8'h01);
      tick_clk();
      check("d0_after_midreset2", out0, 8'h03);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/led_sang_dan_tat_het.md
Name: led_sang_dan_tat_het

Overview:
- Free-running LED pattern generator ("LEDs light up one by one, then all turn off").
- Drives an 8-bit LED bank with a fill pattern from LSB upward (0x01, 0x03, … 0xFF).
- Holds all-on for a configurable number of steps, then clears to 0x00 and repeats forever.
- Sits directly behind a board-level LED output; it has no control inputs besides clock and reset.

Parameters:
- WIDTH, 8: number of LEDs, i.e. width of `out`. Legal range ≥2.
- TICK_DIV, 1: clock cycles per pattern step. Legal range ≥1; 1 means one step per clock.
- HOLD_STEPS, 1: steps for which all-ones stays visible. Legal range ≥1.
- BLINK_COUNT, 2: number of off/on blink pairs. Used only with LED_BLINK_EN; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- out  output  WIDTH  LED drive, 1 = LED on, registered

Interface (already decided): one clock `clk`; `reset` is synchronous and active-high.

Behaviour:
- All state is registered. `out` comes directly from a flop, with no combinational path from inputs.
- Power-up: every register has a declaration initial value equal to its reset value. A bench that never asserts reset must therefore see the defined sequence, never X.
- Reset (sampled at posedge):
  - `out` = 0.
  - state = S_FILL.
  - Tick counter = 0; hold counter = 0; blink counter = 0.
  - Reset mid-sequence aborts immediately. The sequence restarts from 0x00 on the first non-reset cycle.
- Step tick:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - `tick` = 1 in the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, `tick` is high every cycle.
  - State and `out` change only on cycles where `tick` = 1.
- S_FILL, on tick:
  - `out` <= {out[WIDTH-2:0], 1'b1}.
  - If the new value is all-ones, go to S_HOLD with hold counter = 1.
- S_HOLD, on tick:
  - If hold counter == HOLD_STEPS: `out` <= 0 and go to S_FILL (or S_BLINK with the optional feature).
  - Otherwise increment the hold counter; `out` stays all-ones.
- Net effect: all-ones is visible for exactly HOLD_STEPS steps, and 0x00 for one step.
- Cycle period (default): WIDTH + HOLD_STEPS steps.
  - Sequence with defaults: 00,01,03,07,0F,1F,3F,7F,FF, then 00 …
  - Period is 9 clocks with TICK_DIV=1.
- `out` only ever holds values of the form 2^k−1, for k = 0..WIDTH, in S_FILL/S_HOLD.
- Illegal/unreachable state encodings recover to S_FILL with `out` = 0 on the next clock.

Optional Feature:
- Macro: LED_BLINK_EN.
- When defined:
  - Hold exit goes to S_BLINK with `out` = 0 and blink counter = 1.
  - Each tick in S_BLINK toggles `out` between 0 and all-ones and increments the counter.
  - When the counter reaches 2*BLINK_COUNT, `out` <= 0 and go to S_FILL.
  - Visible tail after hold (BLINK_COUNT=2): 00,FF,00,FF, then 00 (the fill start).
  - Period = WIDTH + HOLD_STEPS + 2*BLINK_COUNT steps.
- When not defined:
  - No S_BLINK state and no blink counter logic.
  - Behaviour is exactly as in Behaviour above.

Decomposition:
- Package `led_sang_dan_pkg`:
  - State enum typedef: S_FILL, S_HOLD, S_BLINK.
  - Default constants: LED_WIDTH=8, LED_TICK_DIV=1, LED_HOLD_STEPS=1, LED_BLINK_COUNT=2.
- One sub-module `led_step_tick`:
  - Parameter DIV; ports clk, reset, tick.
  - Prescaler used by the top-level FSM.

Test Plan:
1. Defaults, reset held 2 clocks then released → `out` per clock: 00,01,03,07,0F,1F,3F,7F,FF,00,01 …; 9-clock period checked over 3 periods.
2. No reset asserted at all, only clock toggling → `out` is never X; first value 00, then 01,03 … as in scenario 1.
3. TICK_DIV=4 → each value is held exactly 4 clocks; FF to 00 transition occurs at clock 36 after reset release.
4. HOLD_STEPS=3 → FF visible for 3 consecutive steps, 00 for 1 step; period 11.
5. Reset asserted while `out`=0x1F → next clock `out`=00; following clock `out`=01.
6. LED_BLINK_EN defined, BLINK_COUNT=2 → after FF: 00,FF,00,FF,00,01,03 …; period 13 steps.
